// File: rtl/dragster_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dragster_spi_responder                                       |
// | Description : SPI mode-0 responder. Receives 16-bit frames {data, addr}    |
// |               into a small register file, flags short/long frames and      |
// |               out-of-range addresses, and shifts back the register named   |
// |               by the last valid frame on miso during the next frame.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dragster_spi_responder #(
  parameter int NUM_REGISTERS = 10,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sclk,
  input  logic                       ss_n,
  input  logic                       mosi,
  output logic                       miso,
  output logic [8*NUM_REGISTERS-1:0] reg_file,
  output logic                       wr_strobe,
  output logic [3:0]                 wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       frame_error,
  output logic                       addr_error
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHIFT   = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;
  localparam logic [4:0] CNT_FULL   = 5'd16;
  localparam logic [4:0] CNT_SAT    = 5'd17;
  localparam logic [4:0] NUM_REGS_5 = 5'(NUM_REGISTERS);

  // synchronizer chains and previous-value flops for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q,   ss_prev_d;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  // FSM and datapath state
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]  regs_q [NUM_REGISTERS];
  logic [7:0]  regs_d [NUM_REGISTERS];
  logic        wr_strobe_q, wr_strobe_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        frame_error_q, frame_error_d;
  logic        addr_error_q, addr_error_d;

  logic        frame_start, frame_end;
  logic [3:0]  addr_idx;
  logic        addr_ok;
  logic [7:0]  rd_data;

  // Next values of the synchronizer chains: new sample enters at bit 0
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0],   ss_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    ss_prev_d   = ss_sync_q[SYNC_STAGES-1];
  end

  // Synchronizer registers; ss_n resets low so a select already active at
  // reset release never looks like a fresh falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;

  // A select fall outside SHIFT starts a frame (IDLE, or COMMIT back-to-back)
  assign frame_start = ss_fall && (state_q != ST_SHIFT);
  assign frame_end   = ss_rise && (state_q == ST_SHIFT);
  assign addr_idx    = shift_q[3:0];
  assign addr_ok     = {1'b0, addr_idx} < NUM_REGS_5;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ss_fall) state_d = ST_SHIFT;
      ST_SHIFT:  if (ss_rise) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ss_fall ? ST_SHIFT : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Readback mux; a pointer past the implemented registers matches nothing
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      if (rd_ptr_q == 4'(i)) rd_data = regs_q[i];
    end
  end

  // Output and datapath logic; the commit decision is taken on the
  // SHIFT->COMMIT transition so register write and strobe land together
  // in the COMMIT cycle
  always_comb begin
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    tx_d          = tx_q;
    rd_ptr_d      = rd_ptr_q;
    regs_d        = regs_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_strobe_d   = 1'b0;
    addr_error_d  = 1'b0;
    frame_error_d = 1'b0;
    if (frame_start) begin
      cnt_d   = 5'd0;
      shift_d = 16'h0000;
      tx_d    = rd_data;
    end else if (state_q == ST_SHIFT) begin
      if (sclk_rise) begin
        shift_d = {shift_q[14:0], mosi_s};
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
      end
      if (sclk_fall) tx_d = {tx_q[6:0], 1'b0};
      if (frame_end) begin
        if (cnt_q == CNT_FULL) begin
          rd_ptr_d = addr_idx;
          if (addr_ok) begin
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_idx;
            wr_data_d   = shift_q[15:8];
            for (int i = 0; i < NUM_REGISTERS; i++) begin
              if (addr_idx == 4'(i)) regs_d[i] = shift_q[15:8];
            end
          end else begin
            addr_error_d = 1'b1;
          end
        end else begin
          frame_error_d = 1'b1;
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= 5'd0;
      shift_q       <= 16'h0000;
      tx_q          <= 8'h00;
      rd_ptr_q      <= 4'd0;
      wr_strobe_q   <= 1'b0;
      wr_addr_q     <= 4'd0;
      wr_data_q     <= 8'h00;
      frame_error_q <= 1'b0;
      addr_error_q  <= 1'b0;
      for (int i = 0; i < NUM_REGISTERS; i++) regs_q[i] <= 8'h00;
    end else begin
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      tx_q          <= tx_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_strobe_q   <= wr_strobe_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_error_q <= frame_error_d;
      addr_error_q  <= addr_error_d;
      for (int i = 0; i < NUM_REGISTERS; i++) regs_q[i] <= regs_d[i];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGISTERS; gi++) begin : g_flat
      assign reg_file[8*gi +: 8] = regs_q[gi];
    end
  endgenerate

  // Transmit MSB only while the select is active; zeros shift in behind the
  // byte so positions 8 and later read as 0
  assign miso        = tx_q[7] & ~ss_s;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_error = frame_error_q;
  assign addr_error  = addr_error_q;

endmodule
`default_nettype wire

// File: tb/tb_dragster_spi_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dragster_spi_responder                                    |
// | Description : Self-checking bench: directed and random SPI frames against  |
// |               a register-array reference model.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dragster_spi_responder;

  localparam int NUM_REGISTERS = 10;
  localparam int SYNC_STAGES   = 2;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       sclk = 1'b0;
  logic                       ss_n = 1'b1;
  logic                       mosi = 1'b0;
  logic                       miso;
  logic [8*NUM_REGISTERS-1:0] reg_file;
  logic                       wr_strobe;
  logic [3:0]                 wr_addr;
  logic [7:0]                 wr_data;
  logic                       frame_error;
  logic                       addr_error;

  always #5 clk = ~clk;

  dragster_spi_responder #(
    .NUM_REGISTERS(NUM_REGISTERS),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .sclk       (sclk),
    .ss_n       (ss_n),
    .mosi       (mosi),
    .miso       (miso),
    .reg_file   (reg_file),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_error(frame_error),
    .addr_error (addr_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse monitor: counts every high cycle, so a stretched pulse shows up
  int         mon_wr = 0, mon_aerr = 0, mon_ferr = 0;
  logic [3:0] mon_addr = 4'd0;
  logic [7:0] mon_data = 8'h00;
  always @(negedge clk) begin
    if (wr_strobe) begin
      mon_wr++;
      mon_addr = wr_addr;
      mon_data = wr_data;
    end
    if (addr_error)  mon_aerr++;
    if (frame_error) mon_ferr++;
  end

  // Reference model: register array, read pointer and expected event counts
  logic [7:0] m_regs [16];
  int         m_ptr = 0;
  int         exp_wr = 0, exp_aerr = 0, exp_ferr = 0;
  logic [3:0] exp_addr = 4'd0;
  logic [7:0] exp_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
  endtask

  task automatic check_counts(input string tag);
    check({tag, " wr_count"},   mon_wr,   exp_wr);
    check({tag, " aerr_count"}, mon_aerr, exp_aerr);
    check({tag, " ferr_count"}, mon_ferr, exp_ferr);
    if (exp_wr > 0) begin
      check({tag, " wr_addr"}, {28'd0, mon_addr}, {28'd0, exp_addr});
      check({tag, " wr_data"}, {24'd0, mon_data}, {24'd0, exp_data});
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGISTERS; i++)
      check($sformatf("%s reg%0d", tag, i), {24'd0, reg_file[8*i +: 8]}, {24'd0, m_regs[i]});
  endtask

  // Clock nbits of data (MSB first) at an 8:1 clk:sclk ratio, sampling miso
  // just before each rising sclk edge
  task automatic shift_bits(input logic [31:0] data, input int nbits,
                            output logic [7:0] rd, output logic extra);
    rd = 8'h00;
    extra = 1'b0;
    for (int k = 0; k < nbits; k++) begin
      mosi = data[nbits-1-k];
      repeat (4) @(negedge clk);
      if (k < 8) rd = {rd[6:0], miso};
      else       extra = extra | miso;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic do_frame(input logic [31:0] data, input int nbits, input int gap, input string tag);
    logic [7:0] exp_rd, rd;
    logic       extra;
    logic [3:0] idx;
    exp_rd = (m_ptr < NUM_REGISTERS) ? m_regs[m_ptr] : 8'h00;
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    shift_bits(data, nbits, rd, extra);
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    if (nbits == 16) begin
      idx   = data[3:0];
      m_ptr = int'(idx);
      if (int'(idx) < NUM_REGISTERS) begin
        m_regs[idx] = data[15:8];
        exp_wr++;
        exp_addr = idx;
        exp_data = data[15:8];
      end else begin
        exp_aerr++;
      end
    end else begin
      exp_ferr++;
    end
    repeat (gap) @(negedge clk);
    if (nbits >= 8) check({tag, " readback"}, {24'd0, rd}, {24'd0, exp_rd});
    check({tag, " miso_tail"}, {31'd0, extra}, 32'd0);
    if (gap >= 6) check_counts(tag);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " miso"},        {31'd0, miso},        32'd0);
    check({tag, " wr_strobe"},   {31'd0, wr_strobe},   32'd0);
    check({tag, " frame_error"}, {31'd0, frame_error}, 32'd0);
    check({tag, " addr_error"},  {31'd0, addr_error},  32'd0);
    check({tag, " wr_addr"},     {28'd0, wr_addr},     32'd0);
    check({tag, " wr_data"},     {24'd0, wr_data},     32'd0);
    check_regs(tag);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    logic        extra;
    logic [31:0] data;
    int          nbits, gap;

    model_clear();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Five writes to distinct registers
    do_frame(32'h1305, 16, 8, "w5");
    do_frame(32'h3202, 16, 8, "w2");
    do_frame(32'hC003, 16, 8, "w3");
    do_frame(32'h1F09, 16, 8, "w9");
    do_frame(32'hAB01, 16, 8, "w1");
    check_regs("after5");

    // Readback of a just-written register
    do_frame(32'h5503, 16, 8, "w3b");
    do_frame(32'h0004, 16, 8, "rd55");

    // Short and long frames
    do_frame(32'h0ABC,  12, 8, "short12");
    do_frame(32'h1AB07, 17, 8, "long17");
    do_frame(32'hFFFFF, 20, 8, "long20");
    check_regs("after_ferr");

    // Out-of-range index, then readback of it yields zero
    do_frame(32'h770C, 16, 8, "aerr");
    do_frame(32'h6605, 16, 8, "rd_oob");

    // Back-to-back frames with a 2-clk select gap
    do_frame(32'h9107, 16, 2, "b2b_a");
    do_frame(32'h9208, 16, 8, "b2b_b");
    check_regs("after_b2b");

    // Random frames: mostly 16 bits, some bad lengths, random gaps
    for (int n = 0; n < 40; n++) begin
      nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
      data  = $urandom;
      gap   = int'($urandom_range(2, 8));
      do_frame(data, nbits, gap, $sformatf("rnd%0d", n));
    end
    repeat (10) @(negedge clk);
    check_counts("rnd_end");
    check_regs("rnd_end");

    // Reset in the middle of a frame, then finish the old frame after release
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    shift_bits(32'h000000AB, 8, rd, extra);
    reset = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check_outputs_zero("midreset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    shift_bits(32'h00000001, 8, rd, extra);
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (10) @(negedge clk);
    check_counts("abandoned");
    check_regs("abandoned");
    do_frame(32'hAB01, 16, 8, "post_reset");
    check_regs("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
